sd_in_out_buf: RTL and testbench

- Two-stage srdy/drdy pipeline buffer: an input stage followed by an output stage.
- Consumer side (c_*) accepts data from an upstream producer; producer side (p_*) presents it downstream.
- All handshake outputs are registered: c_drdy, p_srdy and p_data are flop outputs, so there is no combinational path between the c and p interfaces.
- Used as the read-data rebuffer behind one-cycle-latency memories in FIFO tails, and as a general timing-closure stage.

---
 rtl/sd_in_stage.sv | 51 +++++
 rtl/sd_out_stage.sv | 44 ++++
 rtl/sd_in_out_buf.sv | 42 ++++
 tb/tb_sd_in_out_buf.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sd_in_stage.sv
// Input half of the srdy/drdy rebuffer: a one-word skid register behind a
// registered c_drdy, so the upstream never sees a combinational ready path.
module sd_in_stage #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             ip_srdy,
  input  logic             ip_drdy,
  output logic [width-1:0] ip_data
);

  logic             hold_v_q, hold_v_d;
  logic [width-1:0] hold_d_q, hold_d_d;
  logic             c_drdy_q, c_drdy_d;
  logic             c_xfer;

  assign c_xfer  = c_srdy & c_drdy_q;
  assign ip_srdy = hold_v_q | c_xfer;
  assign ip_data = hold_v_q ? hold_d_q : c_data;
  assign c_drdy  = c_drdy_q;

  always_comb begin
    hold_v_d = hold_v_q;
    hold_d_d = hold_d_q;
    // A word accepted while the output stage is stalled parks in the skid slot.
    if (c_xfer && !ip_drdy) begin
      hold_v_d = 1'b1;
      hold_d_d = c_data;
    end else if (hold_v_q && ip_drdy) begin
      hold_v_d = 1'b0;
    end
    c_drdy_d = !hold_v_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q <= 1'b0;
      hold_d_q <= '0;
      c_drdy_q <= 1'b0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_d_q <= hold_d_d;
      c_drdy_q <= c_drdy_d;
    end
  end

endmodule

// File: rtl/sd_out_stage.sv
// Output half of the rebuffer: registered p_srdy/p_data with a ready that
// lets the register reload in the same cycle its word is taken.
module sd_out_stage #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_srdy,
  output logic             ic_drdy,
  input  logic [width-1:0] ic_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data
);

  logic             p_srdy_q, p_srdy_d;
  logic [width-1:0] p_data_q, p_data_d;

  assign ic_drdy = p_drdy | !p_srdy_q;
  assign p_srdy  = p_srdy_q;
  assign p_data  = p_data_q;

  always_comb begin
    p_srdy_d = p_srdy_q;
    p_data_d = p_data_q;
    if (ic_srdy && ic_drdy) begin
      p_srdy_d = 1'b1;
      p_data_d = ic_data;
    end else if (p_drdy) begin
      p_srdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
    end else begin
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
    end
  end

endmodule

// File: rtl/sd_in_out_buf.sv
// Two-word srdy/drdy pipeline buffer with every handshake output registered,
// cutting all combinational paths between the c and p interfaces.
module sd_in_out_buf #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data
);

  logic             ip_srdy;
  logic             ip_drdy;
  logic [width-1:0] ip_data;

  sd_in_stage #(.width(width)) u_in (
    .clk     (clk),
    .reset   (reset),
    .c_srdy  (c_srdy),
    .c_drdy  (c_drdy),
    .c_data  (c_data),
    .ip_srdy (ip_srdy),
    .ip_drdy (ip_drdy),
    .ip_data (ip_data)
  );

  sd_out_stage #(.width(width)) u_out (
    .clk     (clk),
    .reset   (reset),
    .ic_srdy (ip_srdy),
    .ic_drdy (ip_drdy),
    .ic_data (ip_data),
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data)
  );

endmodule

// File: tb/tb_sd_in_out_buf.sv
// Bench for sd_in_out_buf: directed and random traffic against a queue model
// of a two-word FIFO buffer with registered handshakes.
module tb_sd_in_out_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_srdy;
  logic       c_drdy;
  logic [7:0] c_data;
  logic       p_srdy;
  logic       p_drdy;
  logic [7:0] p_data;

  always #5 clk = ~clk;

  sd_in_out_buf #(.width(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data)
  );

  // Model: words currently buffered, oldest first.
  logic [7:0] mdl_q[$];
  bit         mdl_started;
  bit         mdl_known;
  logic [7:0] mdl_last_out;
  int         vectors;
  int         miscompares;
  int         words_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_c_drdy();
    return mdl_started && (mdl_q.size() < 2);
  endfunction

  function automatic bit exp_p_srdy();
    return mdl_q.size() > 0;
  endfunction

  function automatic logic [7:0] exp_p_data();
    return (mdl_q.size() > 0) ? mdl_q[0] : mdl_last_out;
  endfunction

  // One clock: check outputs, drive inputs, advance the model at the edge.
  task automatic step(input bit rst, input bit cs, input bit pd,
                      input logic [7:0] d, output bit took);
    bit c_x, p_x;
    logic [7:0] w;
    @(negedge clk);
    if (mdl_known) begin
      chk("c_drdy", {31'd0, c_drdy}, {31'd0, exp_c_drdy()});
      chk("p_srdy", {31'd0, p_srdy}, {31'd0, exp_p_srdy()});
      chk("p_data", {24'd0, p_data}, {24'd0, exp_p_data()});
    end
    reset  = rst;
    c_srdy = cs;
    p_drdy = pd;
    c_data = d;
    c_x = !rst && cs && exp_c_drdy();
    p_x = !rst && pd && exp_p_srdy();
    @(posedge clk);
    took = c_x;
    if (rst) begin
      mdl_q.delete();
      mdl_started  = 1'b0;
      mdl_last_out = 8'h00;
      mdl_known    = 1'b1;
    end else begin
      if (p_x) begin
        w = mdl_q.pop_front();
        mdl_last_out = w;
        words_out++;
        $display("out word %0d: %02h", words_out, w);
      end
      if (c_x) mdl_q.push_back(d);
      mdl_started = 1'b1;
    end
  endtask

  initial begin
    bit took;
    int i;
    int cycles;
    logic [7:0] d;
    logic [7:0] bp_words[3];
    vectors = 0;
    miscompares = 0;
    words_out = 0;
    mdl_known = 1'b0;
    mdl_started = 1'b0;
    mdl_last_out = 8'h00;
    reset = 1'b1;
    c_srdy = 1'b0;
    p_drdy = 1'b0;
    c_data = 8'h00;

    // Reset held three cycles with c_srdy asserted.
    for (int k = 0; k < 3; k++) step(1, 1, 0, 8'hEE, took);
    for (int k = 0; k < 2; k++) step(0, 0, 1, 8'h00, took);

    // Back-to-back streaming.
    i = 1;
    cycles = 0;
    while (i <= 16 && cycles < 100) begin
      step(0, 1, 1, i[7:0], took);
      if (took) i++;
      cycles++;
    end
    chk("stream_budget", {31'd0, i > 16}, 32'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 8'h00, took);

    // Backpressure: stall while 0xA0 sits on the output.
    bp_words[0] = 8'hA0;
    bp_words[1] = 8'hA1;
    bp_words[2] = 8'hA2;
    step(0, 1, 1, bp_words[0], took);
    step(0, 1, 0, bp_words[1], took);
    for (int k = 0; k < 4; k++) step(0, 1, 0, bp_words[2], took);
    chk("bp_a2_blocked", {31'd0, took}, 32'd0);
    i = 0;
    while (!took && i < 10) begin
      step(0, 1, 1, bp_words[2], took);
      i++;
    end
    chk("bp_a2_accepted", {31'd0, took}, 32'd1);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 8'h00, took);

    // Mid-operation reset with both slots full.
    step(0, 1, 0, 8'h55, took);
    step(0, 1, 0, 8'h66, took);
    step(0, 0, 0, 8'h00, took);
    chk("full_count", mdl_q.size(), 32'd2);
    step(1, 0, 1, 8'h00, took);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 8'h00, took);

    // Random traffic.
    i = 0;
    cycles = 0;
    d = 8'($urandom);
    while (i < 1000 && cycles < 20000) begin
      step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, d, took);
      if (took) begin
        i++;
        d = 8'($urandom);
      end
      cycles++;
    end
    chk("random_budget", i, 32'd1000);
    cycles = 0;
    while (mdl_q.size() > 0 && cycles < 20) begin
      step(0, 0, 1, 8'h00, took);
      cycles++;
    end
    step(0, 0, 1, 8'h00, took);
    chk("drained", mdl_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
